// File: rtl/bp_branch_stats_collector_pkg.sv
// bp_branch_stats_collector_pkg: shared types for the branch statistics collector
package bp_branch_stats_collector_pkg;
  localparam int prof_types_lp = 5;
  typedef enum logic [2:0] {
    e_prof_br   = 3'd0,
    e_prof_jal  = 3'd1,
    e_prof_jalr = 3'd2,
    e_prof_call = 3'd3,
    e_prof_ret  = 3'd4
  } bp_prof_branch_e;
  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_clear = 2'd1,
    e_dump  = 2'd2
  } bp_prof_state_e;
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: saturating up-counter with synchronous clear
module bp_sat_counter #(
  parameter int width_p     = 32,
  parameter int inc_width_p = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_clear,
  input  logic [inc_width_p-1:0] i_inc,
  output logic [width_p-1:0]     o_count
);
  logic [width_p-1:0] r_count;
  logic [width_p:0]   w_sum;
  assign w_sum   = {1'b0, r_count} + (width_p + 1)'(i_inc);
  assign o_count = r_count;
  // clear beats increment; a carry out pins the count at all-ones
  always_ff @(posedge i_clk)
    if (!i_reset_n || i_clear) r_count <= '0;
    else r_count <= w_sum[width_p] ? '1 : w_sum[width_p-1:0];
endmodule

// File: rtl/bp_branch_stats_collector.sv
// bp_branch_stats_collector: per-type branch counters, direct-mapped branch table, epochs and table dump
module bp_branch_stats_collector
  import bp_branch_stats_collector_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int ctr_width_p   = 32,
  parameter int table_els_p   = 64,
  parameter int tag_width_p   = 12,
  parameter int window_p      = 10000,
  localparam int idx_w_lp     = $clog2(table_els_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 freeze_i,
  input  logic                                 commit_v_i,
  input  logic                                 resolve_v_i,
  input  logic                                 resolve_miss_i,
  input  logic [2:0]                           resolve_type_i,
  input  logic [vaddr_width_p-1:0]             resolve_src_vaddr_i,
  input  logic                                 resolve_src_btb_i,
  input  logic                                 resolve_src_ret_i,
  input  logic                                 clear_i,
  input  logic                                 dump_i,
  output logic                                 busy_o,
  output logic [ctr_width_p-1:0]               instr_cnt_o,
  output logic [ctr_width_p-1:0]               btb_hit_cnt_o,
  output logic [ctr_width_p-1:0]               ras_hit_cnt_o,
  output logic [ctr_width_p-1:0]               drop_cnt_o,
  output logic [ctr_width_p-1:0]               evict_cnt_o,
  output logic [prof_types_lp*ctr_width_p-1:0] type_cnt_o,
  output logic [prof_types_lp*ctr_width_p-1:0] type_miss_o,
  output logic                                 epoch_v_o,
  output logic [ctr_width_p-1:0]               epoch_resolve_o,
  output logic [ctr_width_p-1:0]               epoch_miss_o,
  output logic                                 dump_v_o,
  output logic [idx_w_lp-1:0]                  dump_idx_o,
  output logic                                 dump_valid_o,
  output logic [tag_width_p-1:0]               dump_tag_o,
  output logic [ctr_width_p-1:0]               dump_occ_o,
  output logic [ctr_width_p-1:0]               dump_miss_o,
  input  logic                                 dump_yumi_i,
  output logic                                 dump_done_o
);
  localparam int ep_w_lp = (window_p < 2) ? 1 : $clog2(window_p + 1);

  typedef struct packed {
    logic                   valid;
    logic [tag_width_p-1:0] tag;
    logic [ctr_width_p-1:0] occ;
    logic [ctr_width_p-1:0] miss;
  } bp_prof_entry_s;

  bp_prof_entry_s         r_tab [table_els_p];
  bp_prof_state_e         r_state;
  logic [idx_w_lp-1:0]    r_ptr;
  logic                   r_done;
  logic                   r_ep_v;
  logic [ctr_width_p-1:0] r_ep_res, r_ep_miss;

  logic                   w_commit, w_ev, w_tab_upd, w_hit, w_evict, w_close, w_unused;
  logic [idx_w_lp-1:0]    w_idx;
  logic [tag_width_p-1:0] w_tag;
  bp_prof_entry_s         w_old, w_new;
  logic [ep_w_lp-1:0]     w_ep_instr;
  logic [ctr_width_p-1:0] w_ep_res, w_ep_miss;

  assign w_commit  = commit_v_i & ~freeze_i;
  assign w_ev      = resolve_v_i & ~freeze_i & (r_state != e_clear) & ~clear_i;
  assign w_tab_upd = w_ev & (r_state != e_dump);
  assign w_idx     = resolve_src_vaddr_i[2 +: idx_w_lp];
  assign w_tag     = resolve_src_vaddr_i[2 + idx_w_lp +: tag_width_p];
  assign w_old     = r_tab[w_idx];
  assign w_hit     = w_old.valid & (w_old.tag == w_tag);
  assign w_evict   = w_tab_upd & w_old.valid & ~w_hit;
  assign w_close   = (window_p != 0) && w_commit && !clear_i && (w_ep_instr == ep_w_lp'(window_p - 1));
  assign w_unused  = ^resolve_src_vaddr_i;

  // new table entry: accumulate on a tag hit, otherwise (re)install fresh
  always_comb begin
    w_new.valid = 1'b1;
    w_new.tag   = w_tag;
    w_new.occ   = ~w_hit ? ctr_width_p'(1) : (&w_old.occ ? w_old.occ : w_old.occ + ctr_width_p'(1));
    w_new.miss  = ~w_hit ? ctr_width_p'(resolve_miss_i)
                : ((&w_old.miss || !resolve_miss_i) ? w_old.miss : w_old.miss + ctr_width_p'(1));
  end

  // clear sweep zeroes one slot per cycle; otherwise events read-modify-write their slot
  always_ff @(posedge clk_i)
    if (r_state == e_clear) r_tab[r_ptr] <= '0;
    else if (w_tab_upd) r_tab[w_idx] <= w_new;

  // control: clear sweep, dump walk, idle; clear_i preempts any state
  always_ff @(posedge clk_i)
    if (!reset_n_i || clear_i) begin
      r_state <= e_clear;
      r_ptr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        e_idle: if (dump_i) begin
          r_state <= e_dump;
          r_ptr   <= '0;
        end
        e_clear: begin
          r_ptr <= r_ptr + idx_w_lp'(1);
          if (&r_ptr) r_state <= e_idle;
        end
        e_dump: if (dump_yumi_i) begin
          r_ptr <= r_ptr + idx_w_lp'(1);
          if (&r_ptr) begin
            r_state <= e_idle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= e_idle;
      endcase
    end

  // epoch snapshot folds in the closing cycle's own events
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      r_ep_v    <= 1'b0;
      r_ep_res  <= '0;
      r_ep_miss <= '0;
    end else begin
      r_ep_v <= w_close;
      if (w_close) begin
        r_ep_res  <= &w_ep_res ? w_ep_res : w_ep_res + ctr_width_p'(w_ev);
        r_ep_miss <= &w_ep_miss ? w_ep_miss : w_ep_miss + ctr_width_p'(w_ev & resolve_miss_i);
      end
    end

  for (genvar t = 0; t < prof_types_lp; t++) begin : g_type
    logic w_sel;
    assign w_sel = w_ev & (resolve_type_i == 3'(t));
    bp_sat_counter #(.width_p(ctr_width_p)) u_cnt (
      .i_clk(clk_i), .i_reset_n(reset_n_i), .i_clear(clear_i), .i_inc(w_sel),
      .o_count(type_cnt_o[t*ctr_width_p +: ctr_width_p]));
    bp_sat_counter #(.width_p(ctr_width_p)) u_miss (
      .i_clk(clk_i), .i_reset_n(reset_n_i), .i_clear(clear_i), .i_inc(w_sel & resolve_miss_i),
      .o_count(type_miss_o[t*ctr_width_p +: ctr_width_p]));
  end

  bp_sat_counter #(.width_p(ctr_width_p)) u_instr (
    .i_clk(clk_i), .i_reset_n(reset_n_i), .i_clear(clear_i), .i_inc(w_commit), .o_count(instr_cnt_o));
  bp_sat_counter #(.width_p(ctr_width_p)) u_btb (
    .i_clk(clk_i), .i_reset_n(reset_n_i), .i_clear(clear_i), .i_inc(w_ev & resolve_src_btb_i), .o_count(btb_hit_cnt_o));
  bp_sat_counter #(.width_p(ctr_width_p)) u_ras (
    .i_clk(clk_i), .i_reset_n(reset_n_i), .i_clear(clear_i), .i_inc(w_ev & resolve_src_ret_i), .o_count(ras_hit_cnt_o));
  bp_sat_counter #(.width_p(ctr_width_p)) u_drop (
    .i_clk(clk_i), .i_reset_n(reset_n_i), .i_clear(clear_i), .i_inc(w_ev & (r_state == e_dump)), .o_count(drop_cnt_o));
  bp_sat_counter #(.width_p(ctr_width_p)) u_evict (
    .i_clk(clk_i), .i_reset_n(reset_n_i), .i_clear(clear_i), .i_inc(w_evict), .o_count(evict_cnt_o));
  bp_sat_counter #(.width_p(ep_w_lp)) u_ep_instr (
    .i_clk(clk_i), .i_reset_n(reset_n_i), .i_clear(clear_i | w_close), .i_inc(w_commit), .o_count(w_ep_instr));
  bp_sat_counter #(.width_p(ctr_width_p)) u_ep_res (
    .i_clk(clk_i), .i_reset_n(reset_n_i), .i_clear(clear_i | w_close), .i_inc(w_ev), .o_count(w_ep_res));
  bp_sat_counter #(.width_p(ctr_width_p)) u_ep_miss (
    .i_clk(clk_i), .i_reset_n(reset_n_i), .i_clear(clear_i | w_close), .i_inc(w_ev & resolve_miss_i), .o_count(w_ep_miss));

  assign busy_o          = r_state != e_idle;
  assign dump_v_o        = r_state == e_dump;
  assign dump_idx_o      = r_ptr;
  assign dump_valid_o    = r_tab[r_ptr].valid;
  assign dump_tag_o      = r_tab[r_ptr].tag;
  assign dump_occ_o      = r_tab[r_ptr].occ;
  assign dump_miss_o     = r_tab[r_ptr].miss;
  assign dump_done_o     = r_done;
  assign epoch_v_o       = r_ep_v;
  assign epoch_resolve_o = r_ep_res;
  assign epoch_miss_o    = r_ep_miss;
endmodule
